// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the HT1080Z system-RAM arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ram_arb_pkg;

  // Owner of an issued RAM access, carried down the tag pipeline
  typedef enum logic [1:0] {
    NONE = 2'd0,
    VID  = 2'd1,
    DL   = 2'd2,
    CPU  = 2'd3
  } owner_t;

  // Video RAM window and download image base inside the 128 KiB RAM
  localparam logic [16:0] VRAM_BASE = 17'h03C00;
  localparam logic [16:0] DL_BASE   = 17'h10000;

  // Download FIFO entry: {addr[16:0], data[7:0]}
  localparam int DL_ADDR_W  = 17;
  localparam int DL_DATA_W  = 8;
  localparam int DL_ENTRY_W = DL_ADDR_W + DL_DATA_W;

  // Video offset mapped onto the RAM: VRAM_BASE | offset (base is 1 KiB aligned)
  function automatic logic [16:0] vram_addr(input logic [9:0] ofs);
    return VRAM_BASE | {7'h00, ofs};
  endfunction

  // Only the low 128 KiB of the download address space lands in this RAM
  function automatic logic dl_in_range(input logic [24:0] addr);
    return (addr[24:17] == 8'h00);
  endfunction

endpackage

// File: rtl/ram_arbiter_dl_fifo.sv
// Synchronous FIFO buffering download writes ({addr[16:0], data[7:0]} entries).
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none upstream; a push on full is refused unless a pop frees a slot the same cycle.
module dl_fifo
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  logic [DL_ENTRY_W-1:0] i_push_dat,
  input  logic                  i_pop,
  output logic [DL_ENTRY_W-1:0] o_head_dat,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);

  logic [DL_ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_FULL);
  assign w_pop_ok   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push on full still lands
  assign w_push_ok  = i_push & (~o_full | w_pop_ok);
  assign o_head_dat = r_mem[r_rd_ptr];

  // Entry storage; contents are only meaningful while the count says so
  always_ff @(posedge clk_sys) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: video > download FIFO > CPU, one access per clock (RAM_ARB_WDOG_EN adds a CPU starvation watchdog).
// Latency: grant in N drives ram_* in N+1; vid_valid / cpu_ack with read data in N+2.
// Backpressure: video never blocked; download buffered (drop + sticky dl_overflow when full); CPU held off via req/ack.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DL_FIFO_DEPTH = 4,
  parameter int CPU_MAX_WAIT  = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  // HPS download stream
  input  logic        dn_go,
  input  logic        dn_wr,
  input  logic [24:0] dn_addr,
  input  logic [7:0]  dn_data,
  output logic        dl_overflow,
  // Z80 bus
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  // Video fetch
  input  logic        vid_req,
  input  logic [9:0]  vid_addr,
  output logic        vid_valid,
  output logic [7:0]  vid_rdata,
  // RAM macro
  output logic [16:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [16:0] r_ram_addr;
  logic        r_ram_we;
  logic [7:0]  r_ram_wdata;
  owner_t      r_tag1;        // owner of the access currently on ram_*
  owner_t      r_tag2;        // owner of the access whose data is on ram_rdata
  logic        r_cpu_busy;
  logic        r_dl_overflow;
  logic        r_dn_go_d;

  // ---------------------------------------------------------------------------
  // Download FIFO
  // ---------------------------------------------------------------------------
  logic                  w_dl_push;
  logic                  w_dl_pop;
  logic                  w_dl_drop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DL_ENTRY_W-1:0] w_fifo_head;
  logic [DL_ENTRY_W-1:0] w_fifo_in;

  assign w_dl_push = dn_wr & dn_go & dl_in_range(dn_addr);
  assign w_fifo_in = {dn_addr[16:0], dn_data};
  // A byte is lost only when the FIFO is full and nothing drains this cycle
  assign w_dl_drop = w_dl_push & w_fifo_full & ~w_dl_pop;

  dl_fifo #(
    .DEPTH (DL_FIFO_DEPTH)
  ) u_dl_fifo (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .i_push     (w_dl_push),
    .i_push_dat (w_fifo_in),
    .i_pop      (w_dl_pop),
    .o_head_dat (w_fifo_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  logic   w_cpu_want;
  logic   w_cpu_urgent;
  logic   w_gnt_vid;
  logic   w_gnt_dl;
  logic   w_gnt_cpu;
  owner_t w_owner;

  assign w_cpu_want = cpu_req & ~r_cpu_busy;

`ifdef RAM_ARB_WDOG_EN
  localparam int                WAIT_W   = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  logic [WAIT_W-1:0] r_wait_cnt;

  // Once the CPU has been bypassed CPU_MAX_WAIT times it outranks download once
  assign w_cpu_urgent = w_cpu_want & (r_wait_cnt == WAIT_MAX);

  // Count cycles a ready CPU request is passed over; saturate at the threshold
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (w_gnt_cpu) begin
      r_wait_cnt <= '0;
    end else if (w_cpu_want && (r_wait_cnt != WAIT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + WAIT_ONE;
    end
  end
`else
  // Strict priority: the watchdog threshold has no function in this build
  logic w_unused_max_wait;
  assign w_unused_max_wait = (CPU_MAX_WAIT != 0);
  assign w_cpu_urgent      = 1'b0;
`endif

  assign w_gnt_vid = vid_req;
  assign w_gnt_cpu = ~vid_req & w_cpu_want & (w_fifo_empty | w_cpu_urgent);
  assign w_gnt_dl  = ~vid_req & ~w_fifo_empty & ~w_gnt_cpu;
  assign w_dl_pop  = w_gnt_dl;

  // Encode the winner for the tag pipeline
  always_comb begin
    w_owner = NONE;
    if (w_gnt_vid) begin
      w_owner = VID;
    end else if (w_gnt_dl) begin
      w_owner = DL;
    end else if (w_gnt_cpu) begin
      w_owner = CPU;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM command registers
  // ---------------------------------------------------------------------------
  // Register the granted access onto the RAM port; address and data hold when idle
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
    end else if (w_gnt_vid) begin
      r_ram_addr  <= vram_addr(vid_addr);
      r_ram_we    <= 1'b0;
    end else if (w_gnt_dl) begin
      r_ram_addr  <= w_fifo_head[DL_ENTRY_W-1:DL_DATA_W];
      r_ram_wdata <= w_fifo_head[DL_DATA_W-1:0];
      r_ram_we    <= 1'b1;
    end else if (w_gnt_cpu) begin
      r_ram_addr  <= {1'b0, cpu_addr};
      r_ram_wdata <= cpu_wdata;
      r_ram_we    <= cpu_we;
    end else begin
      r_ram_we    <= 1'b0;
    end
  end

  // Two-stage owner pipeline lining up with the RAM's one-cycle read latency
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tag1 <= NONE;
      r_tag2 <= NONE;
    end else begin
      r_tag1 <= w_owner;
      r_tag2 <= r_tag1;
    end
  end

  // CPU may have only one access in flight; released when its ack leaves
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_busy <= 1'b0;
    end else if (w_gnt_cpu) begin
      r_cpu_busy <= 1'b1;
    end else if (r_tag2 == CPU) begin
      r_cpu_busy <= 1'b0;
    end
  end

  // Sticky overflow flag, re-armed by the start of the next download session
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dn_go_d     <= 1'b0;
      r_dl_overflow <= 1'b0;
    end else begin
      r_dn_go_d <= dn_go;
      if (w_dl_drop) begin
        r_dl_overflow <= 1'b1;
      end else if (dn_go && !r_dn_go_d) begin
        r_dl_overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ram_addr    = r_ram_addr;
  assign ram_we      = r_ram_we;
  assign ram_wdata   = r_ram_wdata;
  assign dl_overflow = r_dl_overflow;

  // Read data comes straight off the RAM in the cycle the tag reaches stage 2
  assign vid_valid = (r_tag2 == VID);
  assign vid_rdata = vid_valid ? ram_rdata : 8'h00;
  assign cpu_ack   = (r_tag2 == CPU);
  assign cpu_rdata = cpu_ack ? ram_rdata : 8'h00;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Single-port system-RAM arbiter for the HT1080Z core. It sits between the RAM macro and three requesters:
- the video fetch, which has the highest priority and a fixed latency;
- the HPS download stream (`dn_*`), which holds the boot ROM and cassette image at 0x10000 and upward and cannot be stalled, so it is buffered in a FIFO;
- the Z80 bus, which uses a request/acknowledge handshake.

The arbiter issues at most one RAM access per clock.

## Interface
Parameters:
- DL_FIFO_DEPTH, 4, download write FIFO entries (power of two, ≥2)
- CPU_MAX_WAIT, 8, cycles a pending CPU request may be bypassed by download traffic (watchdog build only)

Ports:
- clk_sys  in  1  system clock (42 MHz)
- reset_n  in  1  asynchronous, active-low reset
- dn_go  in  1  download active
- dn_wr  in  1  one-cycle download write strobe
- dn_addr  in  25  download byte address
- dn_data  in  8  download byte
- dl_overflow  out  1  sticky: a download byte was dropped
- cpu_req  in  1  CPU access request, level, held until ack
- cpu_we  in  1  1 = write
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid with cpu_ack
- vid_req  in  1  video read strobe
- vid_addr  in  10  offset into video RAM (0x3C00 base)
- vid_valid  out  1  video data valid pulse
- vid_rdata  out  8  video byte
- ram_addr  out  17  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, one cycle after address

## Operation
- Grant order each cycle, decided from the current inputs and state: video, then download FIFO not empty, then CPU (cpu_req & !cpu_busy).
- Video grant: ram_addr = {7'h0F, vid_addr}; this is 0x03C00 + vid_addr. ram_we = 0. Video is never blocked.
- Download grant: pop the FIFO head and write it. ram_addr = dn_addr[16:0]; ram_we = 1.
- CPU grant: ram_addr = {1'b0, cpu_addr}; ram_we = cpu_we. Set cpu_busy. Clear cpu_busy on cpu_ack.
- FIFO push: dn_wr & dn_go & (dn_addr[24:17] == 0). Bytes with an out-of-range address are silently discarded.
- Push while the FIFO is full: drop the byte and set dl_overflow.
- Push and pop in the same cycle on a full FIFO: the push is accepted.
- dl_overflow clears on a dn_go rising edge.
- Leftover FIFO entries keep draining after dn_go falls.
- The owner of each issued access is tracked in a two-stage tag pipeline of {NONE, VID, DL, CPU}. It routes read data and acknowledges.

## Timing
- Grant in cycle N drives the ram_* registers, which are valid in cycle N+1.
- ram_rdata is captured at N+2.
- vid_valid and vid_rdata are asserted in cycle N+2, where N is the vid_req cycle. The video latency is exactly 2.
- cpu_ack is asserted at N+2 for both reads and writes; cpu_rdata is valid with it. The CPU must deassert or change cpu_req in the cycle after ack.
- Back-to-back CPU requests: the earliest regrant is the cycle after ack, i.e. one access every 3 cycles.
- Values during reset_n low and after release:
  - ram_we, cpu_ack, vid_valid, dl_overflow are 0.
  - ram_addr, ram_wdata, cpu_rdata, vid_rdata are 0.
  - The FIFO is empty, cpu_busy is 0, and all tags are NONE.
- Reset asserted mid-access: the in-flight access is abandoned and no ack is issued afterwards.
- The FIFO drains at up to 1 entry per cycle when there is no video traffic. The sustained download rate must stay below that.

## Configuration
- RAM_ARB_WDOG_EN defined: a CPU wait counter increments each cycle that cpu_req & !cpu_busy is true and the CPU is not granted.
  - When the counter reaches CPU_MAX_WAIT, the CPU takes priority over download for one grant. Video still wins.
  - The counter clears on a CPU grant.
- RAM_ARB_WDOG_EN undefined: strict priority; the counter logic is absent.

## Structure
- Package ram_arb_pkg holds:
  - owner_t enum (NONE, VID, DL, CPU);
  - VRAM_BASE = 17'h03C00;
  - DL_BASE = 17'h10000.
- Sub-module dl_fifo: synchronous FIFO with {addr[16:0], data[7:0]} entries, push/pop, full/empty, depth DL_FIFO_DEPTH.

## Test plan
- CPU write to 0x4000 with 0x5A, then read 0x4000 → ram_we pulse at 0x04000 and cpu_ack at N+2; the read acks with cpu_rdata = 0x5A.
- vid_req with vid_addr = 0x005 in the same cycle as cpu_req → RAM sees 0x03C05 first; vid_valid at +2; CPU acked one cycle later.
- dn_go = 1 and five dn_wr strobes on consecutive cycles with vid_req held high (depth 4) → four writes appear at 0x10000+ after video ends; dl_overflow = 1; the next dn_go rise clears it.
- dn_addr = 0x20000 with dn_wr → no push and no RAM write.
- RAM_ARB_WDOG_EN, CPU_MAX_WAIT = 8, continuous download traffic plus cpu_req → CPU granted no later than 9 cycles after request.
- reset_n pulsed low one cycle after a CPU grant → no cpu_ack; all outputs 0; FIFO empty.
